result_serializer: RTL
======================

Name: result_serializer

Overview:
Parallel-to-serial transmitter for the size-exploration harness. It captures a WIDTH-bit result word from the module under exploration and sends it out one bit per shift tick on a single pin, so that a host can read back the results bit-serially. The frame is: start bit, WIDTH data bits, optional parity bit. It is the output-side counterpart of the harness's bit-serial operand loaders.

Parameters:
WIDTH, 32, data word width in bits (>=2)
LSB_FIRST, 0, 0 = data sent MSB first; 1 = data sent LSB first
PARITY, 0, 0 = no parity bit; 1 = even parity bit appended after the data

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  result word; sampled only on an accepted load
load_valid  input  1  request to capture data_in
load_ready  output  1  high only in IDLE; a load is accepted when load_valid && load_ready
shift_en  input  1  shift tick; advances the frame by one bit; ignored in IDLE
ser_out  output  1  serial data pin
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the frame completes
bit_idx  output  $clog2(WIDTH)  index of the data bit currently on ser_out (0 = first sent); 0 outside DATA

Behaviour:
- Reset (clk edge with reset=1), from any state:
  - state=IDLE; shift register and parity register cleared.
  - ser_out=0, busy=0, done=0, bit_idx=0, load_ready=1.
  - Any frame in progress is abandoned; no done pulse.
- Output sourcing: all outputs come from registers or are decoded from state only. There is no combinational path from any input to any output.
- ser_out by state: IDLE=0, START=1, DATA=current data bit, PAR=parity bit.
- Data bit order: MSB first when LSB_FIRST=0; LSB first when LSB_FIRST=1.
- IDLE:
  - On load_valid=1: capture data_in into the shift register, compute parity = XOR of data_in, go to START.
  - ser_out=1 and busy=1 from the next cycle.
- START:
  - Holds until shift_en=1, then goes to DATA with bit_idx=0.
  - ser_out shows the first data bit on the following cycle.
- DATA:
  - Each shift_en: advance one bit and increment bit_idx.
  - shift_en while bit_idx=WIDTH-1: go to PAR if PARITY=1, else go to IDLE.
- PAR:
  - ser_out=parity (even parity: total count of ones in data plus parity bit is even).
  - On shift_en, go to IDLE.
- Completion:
  - done=1 for exactly the one cycle in which the state first reads IDLE after the last bit.
  - load_ready=1 in that same cycle. A load_valid in the done cycle is accepted, giving back-to-back frames with no idle gap.
- Latency: accepted load → start bit visible on the next cycle. Total frame length = 1 + WIDTH + PARITY shift ticks.
- Ignored inputs:
  - load_valid while busy: no capture; data_in changes while busy do not affect the frame.
  - shift_en while IDLE: no effect.
- Back-pressure: shift_en may be held low indefinitely; ser_out and bit_idx stay stable.
- shift_en held high continuously: one bit per clock.
- Reset has priority over load_valid and shift_en in the same cycle.

Test Plan:
1. Reset check (WIDTH=32, LSB_FIRST=0, PARITY=0): assert reset for 2 cycles, driving load_valid=1 and shift_en=1 throughout → ser_out=0, busy=0, done=0, load_ready=1; no capture occurs.
2. MSB-first frame: load 0xA5000001, then shift_en high continuously → ser_out sequence is 1 (start), then 1,0,1,0,0,1,0,1, then 23 zeros, then 1. done pulses exactly 33 clocks after the START cycle; busy falls in that same cycle.
3. LSB-first with even parity (LSB_FIRST=1, PARITY=1): load 0x00000007 → bits 1 (start), 1,1,1, 29 zeros, then parity=1. Load 0x00000003 → parity bit=0.
4. Stall and ignore: during DATA at bit_idx=5, drop shift_en for 10 cycles and toggle load_valid with data_in=0xFFFFFFFF → ser_out and bit_idx stay frozen, load_ready=0, and the frame resumes with the original data.
5. Back-to-back: assert load_valid=1 in the done cycle with 0x12345678 → accepted; START (ser_out=1) appears on the next clock with no IDLE gap.
6. Reset mid-frame: assert reset at bit_idx=17 → next cycle is IDLE with ser_out=0 and no done pulse; a fresh load of 0x80000000 then serializes correctly (1 (start), 1, 31 zeros).

Source files
------------

// File: rtl/result_serializer_if.sv
// Handshake and serial-output bundle between the result serializer and its host.
// The master drives the word and the shift ticks. The slave, which is the serializer, drives the pin and the status signals.
interface result_serializer_if #(
  parameter int WIDTH = 32
) ();
  localparam int IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             ser_out;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] bit_idx;

  modport master (
    output data_in, load_valid, shift_en,
    input  load_ready, ser_out, busy, done, bit_idx
  );

  modport slave (
    input  data_in, load_valid, shift_en,
    output load_ready, ser_out, busy, done, bit_idx
  );
endinterface

// File: rtl/result_serializer.sv
// Parallel-to-serial transmitter. Each frame is a start bit, WIDTH data bits and an optional even-parity bit.
// Every output is a register or is decoded from state, so no input reaches a pin combinationally.
module result_serializer #(
  parameter int WIDTH     = 32,
  parameter int LSB_FIRST = 0,
  parameter int PARITY    = 0
) (
  input logic           clk,
  input logic           reset,
  result_serializer_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    PAR   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             r_par;
  logic             w_par_nxt;
  logic [IDX_W-1:0] r_bit_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_ser;

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] d);
    if (LSB_FIRST != 0) return {1'b0, d[WIDTH-1:1]};
    else                return {d[WIDTH-2:0], 1'b0};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_bit_idx <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_par     <= w_par_nxt;
      r_bit_idx <= w_idx_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // done is registered on the final transition, so it lines up with the first IDLE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par;
    w_idx_nxt   = r_bit_idx;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.load_valid) begin
          w_shift_nxt = bus.data_in;
          w_par_nxt   = even_parity(bus.data_in);
          w_idx_nxt   = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (bus.shift_en) begin
          w_idx_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus.shift_en) begin
          if (r_bit_idx == IDX_W'(WIDTH - 1)) begin
            w_idx_nxt = '0;
            if (PARITY != 0) begin
              w_state_nxt = PAR;
            end else begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_shift_nxt = advance(r_shift);
            w_idx_nxt   = r_bit_idx + IDX_W'(1);
          end
        end
      end
      PAR: begin
        if (bus.shift_en) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ser = 1'b0;
    case (r_state)
      START:   w_ser = 1'b1;
      DATA:    w_ser = (LSB_FIRST != 0) ? r_shift[0] : r_shift[WIDTH-1];
      PAR:     w_ser = r_par;
      default: w_ser = 1'b0;
    endcase
  end

  assign bus.ser_out    = w_ser;
  assign bus.busy       = (r_state != IDLE);
  assign bus.load_ready = (r_state == IDLE);
  assign bus.done       = r_done;
  assign bus.bit_idx    = r_bit_idx;
endmodule
